// File: rtl/seg7_bcd_rx_if.sv
// Bundle for the seg7_bcd_rx display-tap side and frame handshake.
// The slave modport is the receiver's view; master is the driver/consumer view.
interface seg7_bcd_rx_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frm_rdy;
  logic        frm_vld;
  logic [15:0] digits;
  logic [3:0]  err;
  logic        ovr;

  modport master (output seg, an, frm_rdy, input frm_vld, digits, err, ovr);
  modport slave  (input seg, an, frm_rdy, output frm_vld, digits, err, ovr);
endinterface

// File: rtl/seg7_bcd_rx.sv
// Recovers a 4-digit BCD frame from a multiplexed active-low 7-segment drive
// and presents it on a valid/ready handshake with a sticky overrun flag.
module seg7_bcd_rx #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  seg7_bcd_rx_if.slave io_bus
);

  localparam logic [3:0] LP_STABLE    = 4'(STABLE_CYC);
  localparam logic [3:0] LP_STABLE_M1 = 4'(STABLE_CYC - 1);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  // Returns {invalid, bcd}; anything outside the digit table maps to 4'hF.
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: f_decode = {1'b0, 4'd0};
      7'b1111001: f_decode = {1'b0, 4'd1};
      7'b0100100: f_decode = {1'b0, 4'd2};
      7'b0110000: f_decode = {1'b0, 4'd3};
      7'b0011001: f_decode = {1'b0, 4'd4};
      7'b0010010: f_decode = {1'b0, 4'd5};
      7'b0000010: f_decode = {1'b0, 4'd6};
      7'b1111000: f_decode = {1'b0, 4'd7};
      7'b0000000: f_decode = {1'b0, 4'd8};
      7'b0011000: f_decode = {1'b0, 4'd9};
      default:    f_decode = {1'b1, 4'hF};
    endcase
  endfunction

  logic [6:0]  r_seg_q;
  logic [3:0]  r_an_q;
  logic [10:0] r_prev;
  logic [3:0]  r_cnt;
  logic [3:0]  r_mask;
  logic [15:0] r_stg_dig;
  logic [3:0]  r_stg_err;
  logic [15:0] r_digits;
  logic [3:0]  r_err;
  logic        r_ovr;
  state_t      r_state;

  logic        w_an_ok;
  logic        w_hold;
  logic        w_cap;
  logic        w_done;
  logic        w_load;
  logic        w_ovr_set;
  logic [1:0]  w_idx;
  logic [3:0]  w_an_lo;
  logic [3:0]  w_cnt_nxt;
  logic [3:0]  w_mask_set;
  logic [3:0]  w_mask_nxt;
  logic [3:0]  w_stg_err_nxt;
  logic [4:0]  w_dec;
  logic [15:0] w_stg_dig_nxt;
  state_t      w_state_nxt;

  // Input sampling and dwell tracking
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg_q <= 7'h7F;
      r_an_q  <= 4'hF;
      r_prev  <= {7'h7F, 4'hF};
      r_cnt   <= 4'd0;
    end else begin
      r_seg_q <= io_bus.seg;
      r_an_q  <= io_bus.an;
      r_prev  <= {r_seg_q, r_an_q};
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Exactly one low enable selects a digit; capture fires once per dwell
  always_comb begin
    w_an_lo = ~r_an_q;
    w_an_ok = (w_an_lo != 4'd0) && ((w_an_lo & (w_an_lo - 4'd1)) == 4'd0);
    w_hold  = w_an_ok && ({r_seg_q, r_an_q} == r_prev);
    w_cap   = w_hold && (r_cnt == LP_STABLE_M1);
    w_dec   = f_decode(r_seg_q);
    case (r_an_q)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
    if (!w_hold) begin
      w_cnt_nxt = 4'd0;
    end else if (r_cnt == LP_STABLE) begin
      w_cnt_nxt = r_cnt;
    end else begin
      w_cnt_nxt = r_cnt + 4'd1;
    end
  end

  // Staging update; a completing capture hands the frame over and clears the mask
  always_comb begin
    w_stg_dig_nxt = r_stg_dig;
    w_stg_err_nxt = r_stg_err;
    w_mask_set    = r_mask;
    if (w_cap) begin
      w_stg_dig_nxt[{w_idx, 2'b00} +: 4] = w_dec[3:0];
      w_stg_err_nxt[w_idx]               = w_dec[4];
      w_mask_set                         = r_mask | (4'b0001 << w_idx);
    end else begin
      w_mask_set = r_mask;
    end
    w_done     = w_cap && (w_mask_set == 4'hF);
    w_mask_nxt = w_done ? 4'h0 : w_mask_set;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask    <= 4'h0;
      r_stg_dig <= 16'h0000;
      r_stg_err <= 4'h0;
    end else begin
      r_mask    <= w_mask_nxt;
      r_stg_dig <= w_stg_dig_nxt;
      r_stg_err <= w_stg_err_nxt;
    end
  end

  // Output FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output FSM: next state
  always_comb begin
    case (r_state)
      S_EMPTY: w_state_nxt = w_done ? S_FULL : S_EMPTY;
      S_FULL: begin
        if (io_bus.frm_rdy) begin
          w_state_nxt = w_done ? S_FULL : S_EMPTY;
        end else begin
          w_state_nxt = S_FULL;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Output FSM: frame load and overrun decisions
  always_comb begin
    w_load    = 1'b0;
    w_ovr_set = 1'b0;
    case (r_state)
      S_EMPTY: w_load = w_done;
      S_FULL: begin
        w_load    = w_done && io_bus.frm_rdy;
        w_ovr_set = w_done && !io_bus.frm_rdy;
      end
      default: begin
        w_load    = 1'b0;
        w_ovr_set = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digits <= 16'h0000;
      r_err    <= 4'h0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_load) begin
        r_digits <= w_stg_dig_nxt;
        r_err    <= w_stg_err_nxt;
      end
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign io_bus.frm_vld = (r_state == S_FULL);
  assign io_bus.digits  = r_digits;
  assign io_bus.err     = r_err;
  assign io_bus.ovr     = r_ovr;

endmodule
